// File: rtl/not_pkg.sv
// not_pkg: shared definitions for the not_pipe inversion pipeline.
//   MODE_W  : width of the inversion-mode field
//   mode_e  : inversion mode encodings (PASS, INV_ALL, INV_MASK, INV_ALT)
package not_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_PASS     = 2'b00,
    MODE_INV_ALL  = 2'b01,
    MODE_INV_MASK = 2'b10,
    MODE_INV_ALT  = 2'b11
  } mode_e;

endpackage

// File: rtl/not_skid_fifo.sv
// not_skid_fifo: 2-entry FIFO with valid/ready on both sides.
//   clk, rst_n           : clock, async active-low reset (clears storage)
//   in_valid/in_ready    : upstream handshake; in_ready is a flop output
//   in_data              : upstream data (WIDTH bits)
//   out_valid/out_ready  : downstream handshake
//   out_data             : head-of-queue data (WIDTH bits)
module not_skid_fifo #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic [1:0][WIDTH-1:0] mem_q;
  logic                  rd_ptr_q, wr_ptr_q;
  logic [1:0]            cnt_q, cnt_d;
  logic                  rdy_q;
  logic                  push, pop;

  assign push      = in_valid & rdy_q;
  assign out_valid = (cnt_q != 2'd0);
  assign pop       = out_valid & out_ready;
  assign in_ready  = rdy_q;
  assign out_data  = mem_q[rd_ptr_q];

  always_comb begin
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Ready is registered from next occupancy: a pop while full frees a slot
  // that only becomes visible upstream one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
      rdy_q    <= 1'b0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= in_data;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      cnt_q <= cnt_d;
      rdy_q <= (cnt_d != 2'd2);
    end
  end

endmodule

// File: rtl/not_pipe.sv
// not_pipe: per-beat bit inversion with a 2-entry output FIFO.
//   clk, rst_n           : clock, async active-low reset
//   mode                 : inversion mode (not_pkg::mode_e), sampled per beat
//   mask                 : per-bit invert enable for INV_MASK
//   in_valid/in_ready    : upstream handshake (in_ready registered)
//   in_data              : upstream data
//   out_valid/out_ready  : downstream handshake
//   out_data             : transformed data
//   inv_cnt              : saturating count of beats with any bit inverted
module not_pipe
  import not_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [MODE_W-1:0] mode,
  input  logic [WIDTH-1:0]  mask,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_data,
  output logic [CNT_W-1:0]  inv_cnt
);

  mode_e            mode_s;
  logic             alt_q, alt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] inv_vec, xf_data;
  logic             fifo_rdy, accept;

  assign mode_s = mode_e'(mode);
  assign accept = in_valid & fifo_rdy;

  always_comb begin
    inv_vec = '0;
    case (mode_s)
      MODE_PASS:     inv_vec = '0;
      MODE_INV_ALL:  inv_vec = '1;
      MODE_INV_MASK: inv_vec = mask;
      MODE_INV_ALT:  inv_vec = {WIDTH{alt_q}};
    endcase
  end

  assign xf_data = in_data ^ inv_vec;

  always_comb begin
    alt_d = alt_q;
    cnt_d = cnt_q;
    if (accept && mode_s == MODE_INV_ALT) alt_d = ~alt_q;
    // Saturate instead of wrapping at all-ones.
    if (accept && (|inv_vec) && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alt_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      alt_q <= alt_d;
      cnt_q <= cnt_d;
    end
  end

  not_skid_fifo #(.WIDTH(WIDTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (fifo_rdy),
    .in_data   (xf_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  assign in_ready = fifo_rdy;
  assign inv_cnt  = cnt_q;

endmodule

// File: tb/tb_not_pipe.sv
// Bench for not_pipe: directed scenarios plus random traffic against a
// queue-based reference model. A second instance with CNT_W=4 shares all
// inputs to exercise counter saturation.
module tb_not_pipe;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] mode;
  logic [7:0] mask, in_data;
  logic       in_valid, out_ready;

  logic        in_ready, out_valid;
  logic [7:0]  out_data;
  logic [15:0] inv_cnt;
  logic        in_ready4, out_valid4;
  logic [7:0]  out_data4;
  logic [3:0]  inv_cnt4;

  always #5 clk = ~clk;

  not_pipe #(.WIDTH(8), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .mask(mask),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .inv_cnt(inv_cnt)
  );

  not_pipe #(.WIDTH(8), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .mode(mode), .mask(mask),
    .in_valid(in_valid), .in_ready(in_ready4), .in_data(in_data),
    .out_valid(out_valid4), .out_ready(out_ready), .out_data(out_data4),
    .inv_cnt(inv_cnt4)
  );

  // Reference model state
  logic [7:0] q[$];
  bit         alt_m, rdy_m;
  int         cnt_m;
  int         n_tests = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outs();
    chk("out_valid", out_valid, q.size() > 0);
    chk("in_ready", in_ready, rdy_m);
    chk("inv_cnt", inv_cnt, cnt_m);
    chk("out_valid4", out_valid4, q.size() > 0);
    chk("in_ready4", in_ready4, rdy_m);
    chk("inv_cnt4", inv_cnt4, (cnt_m > 15) ? 15 : cnt_m);
    if (q.size() > 0) begin
      chk("out_data", out_data, q[0]);
      chk("out_data4", out_data4, q[0]);
    end
  endtask

  // Advance one clock edge, update the model from the inputs in force,
  // then compare outputs shortly after the edge.
  task automatic tick();
    logic       acc, del;
    logic [7:0] v;
    @(posedge clk);
    if (rst_n) begin
      acc = in_valid && rdy_m;
      del = (q.size() > 0) && out_ready;
      if (del) void'(q.pop_front());
      if (acc) begin
        case (mode)
          2'd0:    v = in_data;
          2'd1:    v = ~in_data;
          2'd2:    v = in_data ^ mask;
          default: begin
            v = alt_m ? ~in_data : in_data;
            alt_m = !alt_m;
          end
        endcase
        if (v != in_data) cnt_m++;
        q.push_back(v);
      end
      rdy_m = (q.size() < 2);
    end
    #1 check_outs();
  endtask

  task automatic beat(input logic [1:0] m, input logic [7:0] mk, input logic [7:0] d,
                      input logic v, input logic r);
    mode = m; mask = mk; in_data = d; in_valid = v; out_ready = r;
    tick();
  endtask

  task automatic model_reset();
    q.delete();
    rdy_m = 0; cnt_m = 0; alt_m = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0;
    model_reset();
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_inv_cnt", inv_cnt, 0);
    chk("rst_out_data", out_data, 8'h00);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("rel_in_ready", in_ready, 1'b1);
  endtask

  initial begin
    rst_n = 1'b1; mode = 2'd0; mask = 8'h00; in_data = 8'h00;
    in_valid = 1'b0; out_ready = 1'b0;
    model_reset();
    #2;

    // INV_ALL single beat
    do_reset();
    beat(2'd1, 8'h00, 8'hA5, 1'b1, 1'b1);
    chk("r033_data", out_data, 8'h5A);
    chk("r033_valid", out_valid, 1'b1);
    chk("r033_cnt", inv_cnt, 1);
    beat(2'd0, 8'h00, 8'h00, 1'b0, 1'b1);

    // INV_MASK, then zero mask
    do_reset();
    beat(2'd2, 8'h0F, 8'hFF, 1'b1, 1'b1);
    chk("r034_d0", out_data, 8'hF0);
    chk("r034_c0", inv_cnt, 1);
    beat(2'd2, 8'h00, 8'h3C, 1'b1, 1'b1);
    chk("r034_d1", out_data, 8'h3C);
    chk("r034_c1", inv_cnt, 1);
    beat(2'd0, 8'h00, 8'h00, 1'b0, 1'b1);

    // INV_ALT alternation starting with pass-through
    do_reset();
    beat(2'd3, 8'h00, 8'h00, 1'b1, 1'b1); chk("r035_0", out_data, 8'h00);
    beat(2'd3, 8'h00, 8'h00, 1'b1, 1'b1); chk("r035_1", out_data, 8'hFF);
    beat(2'd3, 8'h00, 8'h00, 1'b1, 1'b1); chk("r035_2", out_data, 8'h00);
    beat(2'd3, 8'h00, 8'h00, 1'b1, 1'b1); chk("r035_3", out_data, 8'hFF);
    chk("r035_cnt", inv_cnt, 2);
    beat(2'd0, 8'h00, 8'h00, 1'b0, 1'b1);

    // Backpressure: third beat held off while full
    do_reset();
    beat(2'd0, 8'h00, 8'h11, 1'b1, 1'b0);
    beat(2'd0, 8'h00, 8'h22, 1'b1, 1'b0);
    chk("r036_full_rdy", in_ready, 1'b0);
    beat(2'd0, 8'h00, 8'h33, 1'b1, 1'b0);
    chk("r036_stall_d", out_data, 8'h11);
    beat(2'd0, 8'h00, 8'h33, 1'b1, 1'b0);
    chk("r036_stall_d2", out_data, 8'h11);
    beat(2'd0, 8'h00, 8'h33, 1'b1, 1'b1);
    chk("r036_d22", out_data, 8'h22);
    chk("r036_rdy_back", in_ready, 1'b1);
    beat(2'd0, 8'h00, 8'h33, 1'b1, 1'b1);
    chk("r036_d33", out_data, 8'h33);
    beat(2'd0, 8'h00, 8'h00, 1'b0, 1'b1);
    chk("r036_empty", out_valid, 1'b0);

    // Counter saturation on the narrow instance
    do_reset();
    for (int i = 0; i < 20; i++) beat(2'd1, 8'h00, 8'(i), 1'b1, 1'b1);
    chk("r037_sat", inv_cnt4, 4'd15);
    chk("r037_wide", inv_cnt, 20);
    beat(2'd0, 8'h00, 8'h00, 1'b0, 1'b1);

    // Async reset with two beats stored
    do_reset();
    beat(2'd1, 8'h00, 8'h0F, 1'b1, 1'b0);
    beat(2'd1, 8'h00, 8'hF0, 1'b1, 1'b0);
    in_valid = 1'b0;
    #3 rst_n = 1'b0;
    model_reset();
    #1;
    chk("r038_valid", out_valid, 1'b0);
    chk("r038_cnt", inv_cnt, 0);
    chk("r038_cnt4", inv_cnt4, 0);
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    chk("r038_rdy", in_ready, 1'b1);
    for (int i = 0; i < 3; i++) tick();

    // Random traffic
    for (int i = 0; i < 500; i++) begin
      logic [7:0] mk;
      mk = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      beat(2'($urandom_range(0, 3)), mk, 8'($urandom),
           $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6);
    end
    for (int i = 0; i < 4; i++) beat(2'd0, 8'h00, 8'h00, 1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/not_pipe.md
NOT_PIPE -- requirements
Module: not_pipe

Interface
REQ-001 Parameter WIDTH, default 8: data width in bits, legal range 1..64.
REQ-002 Parameter CNT_W, default 16: width of the inverted-beat counter, legal range 4..32.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 mode  input  2  inversion mode, sampled per accepted beat: 00 PASS, 01 INV_ALL, 10 INV_MASK, 11 INV_ALT.
REQ-006 mask  input  WIDTH  per-bit invert enable for INV_MASK, sampled per accepted beat.
REQ-007 in_valid  input  1  upstream beat present.
REQ-008 in_ready  output  1  block can accept a beat.
REQ-009 in_data  input  WIDTH  upstream data.
REQ-010 out_valid  output  1  downstream beat present.
REQ-011 out_ready  input  1  downstream accepts the beat.
REQ-012 out_data  output  WIDTH  transformed data.
REQ-013 inv_cnt  output  CNT_W  saturating count of accepted beats with at least one inverted bit.

Function
REQ-014 A beat is accepted when in_valid and in_ready are both high on a rising edge, and delivered when out_valid and out_ready are both high.
REQ-015 Transform at acceptance: PASS gives in_data; INV_ALL gives ~in_data; INV_MASK gives in_data ^ mask; INV_ALT gives ~in_data when alt_phase=1, else in_data.
REQ-016 alt_phase resets to 0 and toggles on every beat accepted in INV_ALT mode, so the first INV_ALT beat passes unchanged. It holds its value across beats in other modes.
REQ-017 Transformed data is stored in a 2-entry FIFO. Latency is 1 cycle: an accepted beat appears on out_data with out_valid high in the next cycle when the FIFO was empty.
REQ-018 in_ready is driven directly from a register and is high only when the FIFO holds fewer than 2 entries. There is no combinational path from out_ready to in_ready.
REQ-019 Full FIFO with simultaneous delivery: in_ready is low that cycle, so no beat is accepted. In the next cycle in_ready is high.
REQ-020 Simultaneous accept and deliver with 1 entry stored: occupancy stays at 1, order is preserved, and no cycle is lost.
REQ-021 Throughput is 1 beat per cycle while out_ready is held high.
REQ-022 out_data holds stable while out_valid is high and out_ready is low. out_valid is never withdrawn without a delivery.
REQ-023 Beats are delivered in acceptance order. None is dropped or duplicated.
REQ-024 inv_cnt increments by 1 on each accepted beat whose applied invert vector is non-zero. It saturates at 2^CNT_W-1 and does not wrap.
REQ-025 Under INV_MASK with mask=0, the beat passes unchanged and inv_cnt does not increment.
REQ-026 A mode or mask change affects only beats accepted after the change. Stored beats are not altered.

Reset
REQ-027 While rst_n=0: out_valid=0, in_ready=0, inv_cnt=0, alt_phase=0, FIFO empty, and out_data=0.
REQ-028 in_ready rises in the first clock edge after rst_n deasserts.
REQ-029 Reset asserted mid-transfer discards all stored beats immediately and asynchronously.

Structure
REQ-030 The mode encodings (PASS, INV_ALL, INV_MASK, INV_ALT) and their 2-bit width are defined in a shared package, not_pkg.
REQ-031 The 2-entry FIFO is a sub-module, not_skid_fifo, parametrised by WIDTH, with valid/ready on both sides and a registered in_ready.
REQ-032 The transform logic and inv_cnt live in not_pipe. Expected implementation size is 120-400 lines.

Verification
REQ-033 Reset, then INV_ALL, in_data=0xA5, out_ready=1 -> next cycle out_data=0x5A, out_valid=1, inv_cnt=1.
REQ-034 INV_MASK with mask=0x0F, in_data=0xFF, then mask=0x00, in_data=0x3C -> outputs 0xF0, then 0x3C; inv_cnt goes from 0 to 1 and stays at 1.
REQ-035 INV_ALT with 4 beats of 0x00, out_ready=1 -> outputs 0x00, 0xFF, 0x00, 0xFF; inv_cnt=2.
REQ-036 PASS with out_ready=0 and 3 beats offered (0x11, 0x22, 0x33) -> 0x11 and 0x22 accepted, in_ready low, 0x33 held. Then out_ready=1 -> 0x11, 0x22, 0x33 delivered in order, and out_data is stable during the stall.
REQ-037 CNT_W=4 with 20 INV_ALL beats -> inv_cnt reaches 15 and holds at 15.
REQ-038 Reset asserted with 2 beats stored -> out_valid=0 and inv_cnt=0 immediately. After release, in_ready=1 one edge later and no stale beat is emitted.
